ddr_rd_sched: RTL and testbench

DDR_RD_SCHED -- requirements
Module: ddr_rd_sched

---
 rtl/ddr_rd_sched_pkg.sv | 8 +
 rtl/ddr_rd_sched_rr.sv | 22 ++
 rtl/ddr_rd_sched.sv | 107 ++++++++++
 tb/tb_ddr_rd_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_sched_pkg.sv
// ddr_rd_sched_pkg: shared types and widths for the DDR read scheduler.
package ddr_rd_sched_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    localparam int BEAT_W = 64;
    function automatic int burst_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/ddr_rd_sched_rr.sv
// rr_arbiter: picks the first request after the last grant, wrapping around.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
)(
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] next,
    output logic         found
);
    always_comb begin
        next = last;
        found = 1'b0;
        for (int i = N; i >= 1; i--) begin
            automatic logic [W-1:0] idx = W'((int'(last) + i) % N);
            if (req[idx]) begin
                next = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ddr_rd_sched.sv
// ddr_rd_sched: round-robin DDR read command scheduler feeding per-layer weight FIFOs.
module ddr_rd_sched
    import ddr_rd_sched_pkg::*;
#(
    parameter int REQ_NUM    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BURST_LEN  = 16
)(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [REQ_NUM-1:0]                    req_aempty_i,
    input  logic [REQ_NUM-1:0]                    sof_i,
    input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]    cfg_base_i,
    input  logic [REQ_NUM-1:0][LEN_WIDTH-1:0]     cfg_len_i,
    output logic                                  ddr_cmd_valid_o,
    input  logic                                  ddr_cmd_ready_i,
    output logic [ADDR_WIDTH-1:0]                 ddr_cmd_addr_o,
    output logic [burst_w(BURST_LEN)-1:0]         ddr_cmd_burst_o,
    input  logic [BEAT_W-1:0]                     ddr_rd_data_i,
    input  logic                                  ddr_rd_valid_i,
    output logic [BEAT_W-1:0]                     ddr_data_o,
    output logic [REQ_NUM-1:0]                    ddr_data_valid_o,
    output logic [$clog2(REQ_NUM)-1:0]            grant_o,
    output logic                                  busy_o,
    output logic                                  err_o
);
    localparam int GW = $clog2(REQ_NUM);
    localparam int BW = burst_w(BURST_LEN);

    state_t               state, state_nxt;
    logic [REQ_NUM-1:0]   elig;
    logic [GW-1:0]        pick;
    logic                 found, accept, last_beat;
    logic [LEN_WIDTH-1:0] offset [REQ_NUM];
    logic [LEN_WIDTH-1:0] rem, adv;
    logic [BW-1:0]        beats_left;

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_elig
        assign elig[i] = req_aempty_i[i] && cfg_len_i[i] != '0;
    end

    rr_arbiter #(.N(REQ_NUM)) u_arb (
        .req   (elig),
        .last  (grant_o),
        .next  (pick),
        .found (found)
    );

    assign accept    = state == CMD && ddr_cmd_ready_i;
    assign last_beat = state == DATA && ddr_rd_valid_i && beats_left == BW'(1);
    assign rem       = cfg_len_i[pick] - offset[pick];
    assign adv       = offset[grant_o] + LEN_WIDTH'(ddr_cmd_burst_o);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (found ? CMD : IDLE)
                  : state == CMD  ? (ddr_cmd_ready_i ? DATA : CMD)
                  :                 (last_beat ? IDLE : DATA);
    end

    always_comb begin
        ddr_cmd_valid_o = state == CMD;
        busy_o          = state != IDLE;
    end

    // Address and burst are captured at grant so they stay stable while CMD waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_o          <= GW'(REQ_NUM - 1);
            ddr_cmd_addr_o   <= '0;
            ddr_cmd_burst_o  <= '0;
            beats_left       <= '0;
            ddr_data_o       <= '0;
            ddr_data_valid_o <= '0;
            err_o            <= 1'b0;
        end else begin
            ddr_data_valid_o <= '0;
            if (state == IDLE && found) begin
                grant_o         <= pick;
                ddr_cmd_addr_o  <= cfg_base_i[pick] + ADDR_WIDTH'({offset[pick], 3'b000});
                ddr_cmd_burst_o <= rem > LEN_WIDTH'(BURST_LEN) ? BW'(BURST_LEN) : BW'(rem);
            end
            if (accept) beats_left <= ddr_cmd_burst_o;
            if (ddr_rd_valid_i && state == DATA) begin
                ddr_data_o       <= ddr_rd_data_i;
                ddr_data_valid_o <= REQ_NUM'(1) << grant_o;
                beats_left       <= beats_left - BW'(1);
            end else if (ddr_rd_valid_i) begin
                err_o <= 1'b1;
            end
        end
    end

    // Start-of-frame wins over a simultaneous advance.
    for (genvar i = 0; i < REQ_NUM; i++) begin : g_off
        always_ff @(posedge clk or posedge reset) begin
            if (reset)                               offset[i] <= '0;
            else if (sof_i[i])                       offset[i] <= '0;
            else if (accept && grant_o == GW'(i))    offset[i] <= adv >= cfg_len_i[i] ? '0 : adv;
        end
    end
endmodule

// File: tb/tb_ddr_rd_sched.sv
// tb_ddr_rd_sched: randomized transaction-level check of ddr_rd_sched against a queue-free offset model.
module tb_ddr_rd_sched;
    localparam int N = 4, AW = 32, LW = 16, BL = 16;

    logic                    clk = 0, reset = 1;
    logic [N-1:0]            req = '0, sof = '0;
    logic [N-1:0][AW-1:0]    cfg_base = '0;
    logic [N-1:0][LW-1:0]    cfg_len = '0;
    logic                    cmd_valid, ready = 0, rd_valid = 0;
    logic [AW-1:0]           cmd_addr;
    logic [4:0]              cmd_burst;
    logic [63:0]             rd_data = '0, data_o;
    logic [N-1:0]            data_valid;
    logic [1:0]              grant;
    logic                    busy, err;

    int checks = 0, errors = 0;
    int m_off [N];
    int m_last;
    bit m_err;
    int obs_grant, obs_nstb;
    logic [AW-1:0] obs_addr;
    int obs_burst;

    ddr_rd_sched dut (
        .clk(clk), .reset(reset), .req_aempty_i(req), .sof_i(sof),
        .cfg_base_i(cfg_base), .cfg_len_i(cfg_len),
        .ddr_cmd_valid_o(cmd_valid), .ddr_cmd_ready_i(ready),
        .ddr_cmd_addr_o(cmd_addr), .ddr_cmd_burst_o(cmd_burst),
        .ddr_rd_data_i(rd_data), .ddr_rd_valid_i(rd_valid),
        .ddr_data_o(data_o), .ddr_data_valid_o(data_valid),
        .grant_o(grant), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r);
        for (int i = 1; i <= N; i++) begin
            int k = (m_last + i) % N;
            if (r[k] && cfg_len[k] != 0) return k;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_off[i] = 0;
        m_last = N - 1;
        m_err = 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_strobe"}, data_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_grant"}, grant, N - 1);
        check({tag, "_addr"}, cmd_addr, 0);
        check({tag, "_burst"}, cmd_burst, 0);
        check({tag, "_data"}, data_o, 0);
    endtask

    task automatic do_reset();
        req = '0; sof = '0; ready = 0; rd_valid = 0;
        reset = 1;
        @(negedge clk);
        check_reset_outputs("rst");
        reset = 0;
        model_reset();
    endtask

    task automatic beat(input logic v, input logic [63:0] d, input int g);
        rd_valid = v;
        rd_data = d;
        @(negedge clk);
        rd_valid = 0;
        if (data_valid != 0) obs_nstb++;
        check("strobe", data_valid, v ? (64'(1) << g) : 64'(0));
        if (v) check("data", data_o, d);
    endtask

    // sof_mode: 0 none, 1 on command accept, 2 mid-data; rst_at: beat index to reset on, -1 none
    task automatic xact(input logic [N-1:0] r, input int dly, input int sof_mode,
                        input int rst_at, input int gap_max);
        int g, b;
        logic [AW-1:0] ea;
        g = rr_pick(r);
        req = r;
        @(negedge clk);
        if (g < 0) begin
            check("nogrant_valid", cmd_valid, 0);
            check("nogrant_busy", busy, 0);
            req = '0;
            obs_grant = -1;
            return;
        end
        b = (cfg_len[g] - m_off[g] > BL) ? BL : cfg_len[g] - m_off[g];
        ea = cfg_base[g] + AW'(8 * m_off[g]);
        obs_grant = grant; obs_addr = cmd_addr; obs_burst = cmd_burst; obs_nstb = 0;
        check("cmd_valid", cmd_valid, 1);
        check("grant", grant, g);
        check("addr", cmd_addr, ea);
        check("burst", cmd_burst, b);
        req = '0;
        for (int i = 0; i < dly; i++) begin
            rd_valid = ($urandom_range(3) == 0);
            rd_data = {$urandom, $urandom};
            @(negedge clk);
            if (rd_valid) m_err = 1;
            rd_valid = 0;
            check("hold_valid", cmd_valid, 1);
            check("hold_addr", cmd_addr, ea);
            check("hold_burst", cmd_burst, b);
            check("hold_strobe", data_valid, 0);
            check("hold_err", err, m_err);
        end
        ready = 1;
        if (sof_mode == 1) sof[g] = 1;
        @(negedge clk);
        ready = 0; sof = '0;
        check("accept_valid", cmd_valid, 0);
        check("accept_busy", busy, 1);
        m_off[g] = (m_off[g] + b >= cfg_len[g]) ? 0 : m_off[g] + b;
        if (sof_mode == 1) m_off[g] = 0;
        m_last = g;
        for (int j = 0; j < b; j++) begin
            repeat ($urandom_range(gap_max)) beat(0, 0, g);
            if (j == rst_at) begin
                rd_valid = 1; rd_data = {$urandom, $urandom};
                reset = 1;
                #1;
                check_reset_outputs("midrst");
                model_reset();
                @(negedge clk);
                reset = 0; rd_valid = 0;
                @(negedge clk);
                check("post_rst_strobe", data_valid, 0);
                check("post_rst_busy", busy, 0);
                return;
            end
            if (sof_mode == 2 && j == b / 2) begin
                sof[g] = 1;
                m_off[g] = 0;
            end
            beat(1, {$urandom, $urandom}, g);
            sof = '0;
        end
        check("nstrobe", obs_nstb, b);
        check("done_busy", busy, 0);
        check("done_err", err, m_err);
    endtask

    task automatic idle_beat();
        rd_valid = 1; rd_data = {$urandom, $urandom};
        @(negedge clk);
        rd_valid = 0;
        m_err = 1;
        check("idle_strobe", data_valid, 0);
        check("idle_err", err, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic new_cfg();
        for (int i = 0; i < N; i++) begin
            cfg_base[i] = {$urandom} & 32'hFFFF_FFF8;
            cfg_len[i] = ($urandom_range(3) == 0) ? 0 : LW'($urandom_range(1, 48));
        end
        sof = '1;
        @(negedge clk);
        sof = '0;
        for (int i = 0; i < N; i++) m_off[i] = 0;
    endtask

    initial begin
        logic [AW-1:0] exp_a [4];
        int exp_b [4];
        exp_a = '{32'h1000, 32'h1080, 32'h1100, 32'h1000};
        exp_b = '{16, 16, 8, 16};
        @(negedge clk);
        do_reset();

        cfg_base[0] = 32'h1000; cfg_len[0] = 40;
        cfg_base[1] = 32'h2000; cfg_len[1] = 32;
        cfg_base[2] = 32'h3000; cfg_len[2] = 16;
        cfg_base[3] = 32'h4000; cfg_len[3] = 48;
        for (int i = 0; i < 4; i++) begin
            xact(4'b0001, 0, 0, -1, 0);
            check("s1_addr", obs_addr, exp_a[i]);
            check("s1_burst", obs_burst, exp_b[i]);
        end

        do_reset();
        for (int i = 0; i < 5; i++) begin
            xact(4'b1111, 0, 0, -1, 1);
            check("s2_grant", obs_grant, i % 4);
            check("s2_nstb", obs_nstb, 16);
        end

        xact(4'b0100, 5, 0, -1, 0);
        xact(4'b0010, 0, 2, -1, 1);
        check("s4_nstb", obs_nstb, 16);
        xact(4'b0010, 0, 0, -1, 0);
        check("s4_addr", obs_addr, cfg_base[1]);
        xact(4'b0010, 2, 1, -1, 0);
        xact(4'b0010, 0, 0, -1, 0);
        check("s4b_addr", obs_addr, cfg_base[1]);

        idle_beat();
        xact(4'b1000, 1, 0, -1, 0);

        xact(4'b0001, 0, 0, 4, 0);
        cfg_len[0] = 40;
        xact(4'b1111, 0, 0, -1, 0);
        check("s6_grant", obs_grant, 0);
        check("s6_addr", obs_addr, cfg_base[0]);

        cfg_len = '0;
        xact(4'b1111, 0, 0, -1, 0);

        for (int it = 0; it < 200; it++) begin
            if (it % 25 == 0) new_cfg();
            if ($urandom_range(15) == 0) idle_beat();
            if ($urandom_range(15) == 0) begin
                int k = $urandom_range(N - 1);
                sof[k] = 1;
                @(negedge clk);
                sof = '0;
                m_off[k] = 0;
            end
            xact(N'($urandom), $urandom_range(3), $urandom_range(2), -1, $urandom_range(2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
